// File: rtl/set_lu_acc.sv
// rtl/set_lu_acc.sv - set-coverage hit evaluator with saturating hit counter
//
// Purpose: runs a start/samples/last sequence. Each accepted coverage vector
// is decoded into a hit according to the mode captured at start, and hits
// are counted with saturation. Results are registered, one cycle latency.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   start_i      begins a run (honoured only when idle)
//   mode_i       hit-logic mode, captured on an accepted start
//   cov_valid_i  covered_i / cov_last_i valid
//   covered_i    bit k = point covered by set k; MSB is set "A"
//   cov_last_i   final sample of the run
//   cov_ready_o  sample accepted when high together with cov_valid_i
//   hit_o        registered hit of the last accepted sample
//   hit_valid_o  one-cycle pulse per accepted sample
//   cnt_o        running hit count (saturating)
//   sat_o        sticky counter-saturated flag for the run
//   busy_o       run in progress (RUN or DONE)
//   done_o       one-cycle pulse at run end
module set_lu_acc #(
  parameter int N_SET   = 3,
  parameter int CNT_W   = 8,
  parameter int MODE_SZ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [MODE_SZ-1:0] mode_i,
  input  logic               cov_valid_i,
  input  logic [N_SET-1:0]   covered_i,
  input  logic               cov_last_i,
  output logic               cov_ready_o,
  output logic               hit_o,
  output logic               hit_valid_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               sat_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [MODE_SZ-1:0] mode_buf;
  logic [3:0]         pop;
  logic               hit_comb;
  logic               accept;

  assign accept = cov_valid_i && cov_ready_o;

  // Population count of the coverage vector (N_SET <= 8 fits in 4 bits).
  always_comb begin
    pop = 4'd0;
    for (int k = 0; k < N_SET; k++) begin
      pop = pop + {3'b000, covered_i[k]};
    end
  end

  always_comb begin
    hit_comb = 1'b0;
    case (mode_buf)
      MODE_SZ'(1): hit_comb = covered_i[N_SET-1];
      MODE_SZ'(2): hit_comb = &covered_i;
      MODE_SZ'(3): hit_comb = (pop == 4'd1);
      MODE_SZ'(4): hit_comb = (pop == 4'd2);
      default:     hit_comb = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cov_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cov_ready_o = 1'b1;
        busy_o      = 1'b1;
        if (cov_valid_i && cov_last_i) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_buf    <= '0;
      cnt_o       <= '0;
      sat_o       <= 1'b0;
      hit_o       <= 1'b0;
      hit_valid_o <= 1'b0;
    end else begin
      hit_valid_o <= 1'b0;
      if (state == S_IDLE && start_i) begin
        mode_buf <= mode_i;
        cnt_o    <= '0;
        sat_o    <= 1'b0;
      end
      if (accept) begin
        hit_valid_o <= 1'b1;
        hit_o       <= hit_comb;
        if (hit_comb) begin
          // Counter holds at all-ones; the overflowing hit flags saturation.
          if (&cnt_o) begin
            sat_o <= 1'b1;
          end else begin
            cnt_o <= cnt_o + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_set_lu_acc.sv
// tb/tb_set_lu_acc.sv - self-checking bench for set_lu_acc
module tb_set_lu_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [2:0] mode_i;
  logic       cov_valid_i;
  logic [2:0] covered_i;
  logic       cov_last_i;

  logic       cov_ready_o, hit_o, hit_valid_o, sat_o, busy_o, done_o;
  logic [7:0] cnt_o;
  logic       cov_ready2, hit2, hit_valid2, sat2, busy2, done2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_lu_acc #(.N_SET(3), .CNT_W(8), .MODE_SZ(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .cov_valid_i(cov_valid_i), .covered_i(covered_i), .cov_last_i(cov_last_i),
    .cov_ready_o(cov_ready_o), .hit_o(hit_o), .hit_valid_o(hit_valid_o),
    .cnt_o(cnt_o), .sat_o(sat_o), .busy_o(busy_o), .done_o(done_o)
  );

  set_lu_acc #(.N_SET(3), .CNT_W(2), .MODE_SZ(3)) dut2 (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .cov_valid_i(cov_valid_i), .covered_i(covered_i), .cov_last_i(cov_last_i),
    .cov_ready_o(cov_ready2), .hit_o(hit2), .hit_valid_o(hit_valid2),
    .cnt_o(cnt2), .sat_o(sat2), .busy_o(busy2), .done_o(done2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_hit(input logic [2:0] mode, input logic [2:0] cov);
    int pop;
    pop = $countones(cov);
    case (mode)
      3'd1:    return cov[2];
      3'd2:    return cov == 3'b111;
      3'd3:    return pop == 1;
      3'd4:    return pop == 2;
      default: return 1'b0;
    endcase
  endfunction

  logic [2:0] smp [0:15];
  int         n_smp;
  int         cnt_exp, cnt2_exp;
  logic       sat_exp, sat2_exp, last_h;

  // Full run: start, samples (optionally gapped), DONE, back to idle.
  task automatic do_run(input logic [2:0] mode, input int gap_max);
    logic h;
    int   gaps;
    start_i = 1'b1; mode_i = mode;
    step();
    start_i = 1'b0;
    cnt_exp = 0; cnt2_exp = 0; sat_exp = 1'b0; sat2_exp = 1'b0;
    chk("run_ready", cov_ready_o, 1'b1);
    chk("run_busy", busy_o, 1'b1);
    chk("run_cnt_clr", cnt_o, 0);
    chk("run_sat_clr", {sat_o, sat2}, 2'b00);
    chk("run_hv0", hit_valid_o, 1'b0);
    for (int i = 0; i < n_smp; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) begin
        cov_valid_i = 1'b0;
        covered_i   = 3'($urandom);
        cov_last_i  = 1'($urandom);
        start_i     = 1'($urandom);
        mode_i      = 3'($urandom);
        step();
        start_i = 1'b0;
        chk("gap_hv", {hit_valid_o, hit_valid2}, 2'b00);
        chk("gap_cnt", cnt_o, cnt_exp);
        chk("gap_done", done_o, 1'b0);
      end
      cov_valid_i = 1'b1;
      covered_i   = smp[i];
      cov_last_i  = (i == n_smp - 1);
      start_i     = 1'($urandom);
      step();
      start_i = 1'b0;
      mode_i  = 3'($urandom);
      h = ref_hit(mode, smp[i]);
      last_h = h;
      if (h) begin
        if (cnt_exp == 255) sat_exp = 1'b1; else cnt_exp++;
        if (cnt2_exp == 3) sat2_exp = 1'b1; else cnt2_exp++;
      end
      chk("smp_hv", {hit_valid_o, hit_valid2}, 2'b11);
      chk("smp_hit", {hit_o, hit2}, {h, h});
      chk("smp_cnt", cnt_o, cnt_exp);
      chk("smp_cnt2", cnt2, cnt2_exp);
      chk("smp_sat", {sat_o, sat2}, {sat_exp, sat2_exp});
      chk("smp_done", done_o, (i == n_smp - 1));
      chk("smp_ready", cov_ready_o, (i != n_smp - 1));
    end
    cov_valid_i = 1'b0;
    cov_last_i  = 1'b0;
    start_i     = 1'($urandom);
    step();
    start_i = 1'b0;
    chk("post_done", done_o, 1'b0);
    chk("post_busy", busy_o, 1'b0);
    chk("post_hv", hit_valid_o, 1'b0);
    chk("post_cnt", cnt_o, cnt_exp);
    chk("post_hit", hit_o, last_h);
    chk("post_sat", {sat_o, sat2}, {sat_exp, sat2_exp});
  endtask

  typedef struct {
    logic [2:0] mode;
    logic [2:0] cov;
    logic       hit;
  } vec_t;

  vec_t tab [0:11];

  initial begin
    tab[0]  = '{3'd1, 3'b100, 1'b1};
    tab[1]  = '{3'd1, 3'b011, 1'b0};
    tab[2]  = '{3'd2, 3'b111, 1'b1};
    tab[3]  = '{3'd2, 3'b110, 1'b0};
    tab[4]  = '{3'd3, 3'b010, 1'b1};
    tab[5]  = '{3'd3, 3'b000, 1'b0};
    tab[6]  = '{3'd3, 3'b101, 1'b0};
    tab[7]  = '{3'd4, 3'b101, 1'b1};
    tab[8]  = '{3'd4, 3'b111, 1'b0};
    tab[9]  = '{3'd0, 3'b111, 1'b0};
    tab[10] = '{3'd5, 3'b100, 1'b0};
    tab[11] = '{3'd4, 3'b100, 1'b0};

    rst = 1'b1; start_i = 1'b0; mode_i = 3'd0;
    cov_valid_i = 1'b0; covered_i = 3'b000; cov_last_i = 1'b0;
    step(); step();
    chk("rst_outs", {cov_ready_o, hit_o, hit_valid_o, sat_o, busy_o, done_o}, 6'b0);
    chk("rst_cnt", cnt_o, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", cov_ready_o, 1'b0);

    // Single-sample decode table
    for (int t = 0; t < 12; t++) begin
      n_smp = 1; smp[0] = tab[t].cov;
      do_run(tab[t].mode, 0);
      chk($sformatf("tab%0d_hit", t), hit_o, tab[t].hit);
      chk($sformatf("tab%0d_cnt", t), cnt_o, tab[t].hit);
    end

    // MODE 4: 011,110,111,101 -> 1,1,0,1, cnt 3
    n_smp = 4; smp[0] = 3'b011; smp[1] = 3'b110; smp[2] = 3'b111; smp[3] = 3'b101;
    do_run(3'd4, 0);
    chk("m4_cnt", cnt_o, 3);

    // MODE 3 with mode_i scrambled mid-run -> 1,1,0,0, cnt 2
    n_smp = 4; smp[0] = 3'b100; smp[1] = 3'b010; smp[2] = 3'b110; smp[3] = 3'b000;
    do_run(3'd3, 0);
    chk("m3_cnt", cnt_o, 2);

    // MODE 2, five 111: 2-bit counter saturates at 3 from 4th hit
    n_smp = 5;
    for (int i = 0; i < 5; i++) smp[i] = 3'b111;
    do_run(3'd2, 0);
    chk("sat_cnt2", cnt2, 2'd3);
    chk("sat_flag2", sat2, 1'b1);
    chk("sat_cnt8", cnt_o, 5);

    // Gapped samples
    n_smp = 6;
    for (int i = 0; i < 6; i++) smp[i] = 3'($urandom);
    do_run(3'd1, 3);

    // Illegal mode 7
    n_smp = 3;
    for (int i = 0; i < 3; i++) smp[i] = 3'b111;
    do_run(3'd7, 0);
    chk("m7_cnt", cnt_o, 0);

    // Reset mid-run after two hits
    start_i = 1'b1; mode_i = 3'd2;
    step();
    start_i = 1'b0;
    cov_valid_i = 1'b1; covered_i = 3'b111; cov_last_i = 1'b0;
    step(); step();
    chk("pre_rst_cnt", cnt_o, 2);
    rst = 1'b1; cov_last_i = 1'b1;
    step();
    chk("abort_outs", {cov_ready_o, hit_o, hit_valid_o, sat_o, busy_o, done_o}, 6'b0);
    chk("abort_cnt", {cnt_o, cnt2}, 10'd0);
    rst = 1'b0; cov_valid_i = 1'b0; cov_last_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", {done_o, busy_o}, 2'b00);
    end
    n_smp = 3;
    for (int i = 0; i < 3; i++) smp[i] = 3'b111;
    do_run(3'd2, 0);
    chk("after_abort_cnt", cnt_o, 3);

    // Randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      n_smp = int'($urandom_range(1, 10));
      for (int i = 0; i < n_smp; i++) smp[i] = 3'($urandom);
      do_run(3'($urandom), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_lu_acc.md
SET_LU_ACC -- requirements
Module: set_lu_acc

Interface
REQ-001 Parameter N_SET, default 3: number of sets per covered vector; legal range 2..8.
REQ-002 Parameter CNT_W, default 8: hit counter width.
REQ-003 Parameter MODE_SZ, default 3: mode field width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle pulse that begins a run; honoured only in IDLE.
REQ-007 mode_i  input  MODE_SZ  hit-logic mode, sampled into mode_buf on an accepted start_i.
REQ-008 cov_valid_i  input  1  covered_i, cov_last_i valid.
REQ-009 covered_i  input  N_SET  bit k = point covered by set k; bit N_SET-1 is set "A".
REQ-010 cov_last_i  input  1  marks final sample of a run.
REQ-011 cov_ready_o  output  1  block accepts a sample.
REQ-012 hit_o  output  1  registered hit result of the last accepted sample.
REQ-013 hit_valid_o  output  1  hit_o valid; one-cycle pulse per accepted sample.
REQ-014 cnt_o  output  CNT_W  running hit count of the current or most recent run.
REQ-015 sat_o  output  1  sticky; counter saturated during the current run.
REQ-016 busy_o  output  1  high in RUN and DONE.
REQ-017 done_o  output  1  one-cycle pulse at run end.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-019 IDLE: cov_ready_o=0; on start_i=1, latch mode_i into mode_buf, clear cnt_o and sat_o, and go to RUN next cycle.
REQ-020 RUN: cov_ready_o=1; a sample is accepted when cov_valid_i=1 and cov_ready_o=1.
REQ-021 Accepted sample with cov_last_i=1: go to DONE next cycle; otherwise stay in RUN.
REQ-022 DONE: cov_ready_o=0, done_o=1 for exactly one cycle, then go to IDLE.
REQ-023 start_i in RUN or DONE SHALL be ignored; mode_i changes after the start_i cycle SHALL have no effect on the run.
REQ-024 Hit decode on mode_buf, with pop = number of set bits in covered_i:
- MODE 1: covered_i[N_SET-1].
- MODE 2: all bits set.
- MODE 3: pop==1.
- MODE 4: pop==2.
- Any other code: 0.
REQ-025 Latency 1: for a sample accepted at cycle t, hit_o, hit_valid_o=1 and the updated cnt_o SHALL appear at t+1.
REQ-026 cnt_o SHALL increment by 1 per accepted hit; at all-ones it SHALL hold, and sat_o SHALL set when a hit arrives while cnt_o is all-ones.
REQ-027 For the final sample accepted at t: hit_valid_o, final cnt_o and done_o SHALL all be asserted at t+1.
REQ-028 cnt_o, sat_o and hit_o SHALL hold their values after DONE until the next accepted start_i.
REQ-029 busy_o SHALL be 1 exactly when the state is RUN or DONE.

Reset
REQ-030 rst=1 SHALL force IDLE and set cnt_o=0, sat_o=0, hit_o=0, hit_valid_o=0, done_o=0, cov_ready_o=0, busy_o=0 and mode_buf=0 at the next edge.
REQ-031 rst SHALL have priority over all other inputs, including mid-run; no done_o SHALL follow an aborted run.

Verification
REQ-032 N_SET=3, MODE 4, samples 011,110,111,101(last) -> hit 1,1,0,1; cnt_o=3; done_o one cycle after the last sample.
REQ-033 MODE 3, samples 100,010,110,000(last), with mode_i changed to 2 mid-run -> hit 1,1,0,0; cnt_o=2.
REQ-034 CNT_W=2, MODE 2, five samples 111 -> cnt_o=3, sat_o=1 from the 4th hit onward.
REQ-035 cov_valid_i gapped, idle cycles between samples -> no hit_valid_o in gap cycles; count unchanged across gaps.
REQ-036 rst asserted in RUN after 2 hits -> all outputs 0 next cycle, no done_o; new start_i -> cnt_o counts from 0.
REQ-037 MODE 7 (illegal), three samples 111 -> hit 0 each, cnt_o=0, done_o pulses normally.
